// File: rtl/tt_art_banner_pkg.sv
// Shared constants and types for the banner transmitter.
// Build option TX_PARITY_EN adds an even-parity bit state to the frame FSM.
package tt_art_banner_pkg;

    localparam int BANNER_LEN = 10;
    localparam int CNT_W      = 10;

    // "TINY ART\r\n", sent from entry 0 upward
    localparam logic [7:0] BANNER_ROM [BANNER_LEN] = '{
        8'h54, 8'h49, 8'h4E, 8'h59, 8'h20,
        8'h41, 8'h52, 8'h54, 8'h0D, 8'h0A
    };

`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;
`endif

endpackage

// File: rtl/tt_art_uart_tx_byte.sv
// Single-byte 8N1 serializer with load/ready handshake and per-bit timer.
// Build option TX_PARITY_EN inserts an even-parity bit before the stop bit.
module tt_art_uart_tx_byte
    import tt_art_banner_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] data,
    output logic       ready,
    output logic       frame_end,
    output logic       txd,
    output tx_state_e  state
);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             bit_last;
`ifdef TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign bit_last  = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign frame_end = (state_q == ST_STOP) && bit_last;
    // Ready on the last stop cycle lets the next frame start with no idle gap
    assign ready     = (state_q == ST_IDLE) || frame_end;
    assign txd       = txd_q;
    assign state     = state_q;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = 1'b1;
`ifdef TX_PARITY_EN
        parity_d  = parity_q;
`endif
        bit_cnt_d = ((state_q == ST_IDLE) || bit_last) ? '0 : bit_cnt_q + 1'b1;

        case (state_q)
            ST_START: begin
                if (bit_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_last) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: begin
                if (bit_last) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_last) state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (load && ready) begin
            state_d   = ST_START;
            bit_cnt_d = '0;
            bit_idx_d = '0;
            shift_d   = data;
`ifdef TX_PARITY_EN
            parity_d  = ^data;
`endif
        end

        // txd is registered from the next state so it lines up with state_q
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef TX_PARITY_EN
            ST_PARITY: txd_d = parity_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
`ifdef TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (ena) begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: rtl/tt_um_art_banner_tx.sv
// Sends the "TINY ART\r\n" banner over UART on a start edge; supports abort and enable freeze.
// Build option TX_PARITY_EN selects 8E1 framing in the byte serializer.
module tt_um_art_banner_tx
    import tt_art_banner_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic       start_prev_q, start_prev_d;
    logic       start_pulse_q, start_pulse_d;
    logic       abort_pend_q, abort_pend_d;
    logic [3:0] index_q, index_d;
    logic       done_q, done_d;

    logic       tx_ready, tx_frame_end, tx_txd;
    tx_state_e  tx_state;
    logic       idle, last_byte, abort_now, begin_tx, chain, load;
    logic [3:0] load_idx;
    logic [7:0] load_data;
    logic       unused_inputs;

    assign unused_inputs = &{1'b0, ui_in[7:2], uio_in};

    always_comb begin
        sync1_d       = ui_in[1:0];
        sync2_d       = sync1_q;
        start_prev_d  = sync2_q[0];
        // Edge is registered once more so txd falls on the third edge after sampling
        start_pulse_d = sync2_q[0] & ~start_prev_q;

        idle      = (tx_state == ST_IDLE);
        last_byte = (index_q == 4'(BANNER_LEN - 1));
        abort_now = abort_pend_q | sync2_q[1];
        begin_tx  = idle & start_pulse_q;
        chain     = tx_frame_end & ~last_byte & ~abort_now;
        load      = tx_ready & (begin_tx | chain);
        load_idx  = chain ? index_q + 4'd1 : 4'd0;

        index_d = index_q;
        if (begin_tx) begin
            index_d = 4'd0;
        end else if (chain) begin
            index_d = load_idx;
        end else if (tx_frame_end) begin
            index_d = 4'd0;
        end

        // Abort is remembered until the current frame's stop bit finishes
        abort_pend_d = (idle | tx_frame_end) ? 1'b0 : abort_now;
        done_d       = tx_frame_end & last_byte & ~abort_now;
    end

    assign load_data = BANNER_ROM[load_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            start_prev_q  <= 1'b0;
            start_pulse_q <= 1'b0;
            abort_pend_q  <= 1'b0;
            index_q       <= '0;
            done_q        <= 1'b0;
        end else if (ena) begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            start_prev_q  <= start_prev_d;
            start_pulse_q <= start_pulse_d;
            abort_pend_q  <= abort_pend_d;
            index_q       <= index_d;
            done_q        <= done_d;
        end
    end

    tt_art_uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .load      (load),
        .data      (load_data),
        .ready     (tx_ready),
        .frame_end (tx_frame_end),
        .txd       (tx_txd),
        .state     (tx_state)
    );

    assign uo_out  = {1'b0, index_q, done_q, ~idle, tx_txd};
    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_art_banner_tx.sv
// Scoreboard bench for tt_um_art_banner_tx with CLKS_PER_BIT=4; honours TX_PARITY_EN.
module tb_tt_um_art_banner_tx;

    localparam int CPB = 4;
`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC  = FRAME_BITS * CPB;
    localparam int BANNER_CYC = 10 * FRAME_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    byte unsigned banner [10] = '{8'h54, 8'h49, 8'h4E, 8'h59, 8'h20,
                                  8'h41, 8'h52, 8'h54, 8'h0D, 8'h0A};

    int n_checks = 0;
    int n_fail   = 0;
    byte unsigned exp_q[$];
    int start_stamp[$];
    int frames_seen = 0, done_cycles = 0, done_run = 0, done_run_max = 0;
    int busy_run = 0, busy_last = 0, cyc_all = 0;

    tt_um_art_banner_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (uo_out[1] && k < 3000) begin
            tick(1);
            k++;
        end
        chk({tag, "_idle_timeout"}, uo_out[1], 0);
    endtask

    task automatic wait_index(input string tag, input int v);
        int k = 0;
        while (uo_out[6:3] != v[3:0] && k < 3000) begin
            tick(1);
            k++;
        end
        chk({tag, "_index_timeout"}, uo_out[6:3], v);
    endtask

    task automatic start_banner(input int n_exp);
        for (int i = 0; i < n_exp; i++) exp_q.push_back(banner[i]);
        ui_in[0] = 1'b1;
        tick(3);
        ui_in[0] = 1'b0;
    endtask

    // UART receiver: counts only cycles in which the DUT was enabled
    initial begin : monitor
        int bit_pos;
        int cyc;
        logic [7:0] rx;
        logic adv;
        bit_pos = -1;
        cyc = 0;
        rx = '0;
        forever begin
            @(posedge clk);
            adv = ena && rst_n;
            if (!rst_n) begin
                bit_pos = -1;
                cyc = 0;
            end
            @(negedge clk);
            cyc_all++;
            if (uo_out[1]) busy_run++;
            else if (busy_run != 0) begin
                busy_last = busy_run;
                busy_run = 0;
            end
            if (uo_out[2]) begin
                done_cycles++;
                done_run++;
                if (done_run > done_run_max) done_run_max = done_run;
            end else begin
                done_run = 0;
            end
            if (adv) begin
                if (bit_pos < 0) begin
                    if (uo_out[0] == 1'b0) begin
                        bit_pos = 0;
                        cyc = 0;
                        start_stamp.push_back(cyc_all);
                    end
                end else begin
                    cyc++;
                    if (cyc == CPB) begin
                        cyc = 0;
                        bit_pos++;
                    end
                    if (cyc == 1) begin
                        if (bit_pos >= 1 && bit_pos <= 8) begin
                            rx[bit_pos-1] = uo_out[0];
`ifdef TX_PARITY_EN
                        end else if (bit_pos == 9) begin
                            chk("parity_bit", uo_out[0], ^rx);
`endif
                        end else if (bit_pos == FRAME_BITS - 1) begin
                            chk("stop_bit", uo_out[0], 1);
                            frames_seen++;
                            $display("frame %0d: byte 0x%02h", frames_seen, rx);
                            chk("frame_expected", exp_q.size() != 0, 1);
                            if (exp_q.size() != 0) chk("rx_byte", rx, exp_q.pop_front());
                            chk("uio_zero", {uio_out, uio_oe}, 0);
                            bit_pos = -1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: time limit reached, got hang expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int d0, f0, lat, txd_h, idx_h;

        // Reset state
        rst_n = 1'b0;
        tick(3);
        chk("reset_uo_out", uo_out, 8'h01);
        chk("reset_uio", {uio_out, uio_oe}, 0);
        rst_n = 1'b1;
        tick(3);
        chk("idle_uo_out", uo_out, 8'h01);

        // Full banner with start latency
        d0 = done_cycles;
        f0 = frames_seen;
        start_stamp.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(banner[i]);
        ui_in[0] = 1'b1;
        lat = 0;
        while (uo_out[0] && lat < 10) begin
            tick(1);
            lat++;
        end
        chk("start_latency", lat - 1, 3);
        chk("busy_at_start", uo_out[1], 1);
        tick(3);
        ui_in[0] = 1'b0;
        wait_idle("banner1");
        chk("done_at_idle", uo_out[2], 1);
        tick(2);
        chk("done_count", done_cycles - d0, 1);
        chk("done_width", done_run_max, 1);
        chk("busy_len", busy_last, BANNER_CYC);
        chk("frames", frames_seen - f0, 10);
        chk("queue_empty", exp_q.size(), 0);
        chk("start_count", start_stamp.size(), 10);
        if (start_stamp.size() >= 2) chk("frame_len", start_stamp[1] - start_stamp[0], FRAME_CYC);
        chk("idle_index", uo_out[6:3], 0);

        // Abort during byte 2 data
        d0 = done_cycles;
        f0 = frames_seen;
        start_banner(3);
        wait_index("abort", 2);
        tick(CPB + 2);
        ui_in[1] = 1'b1;
        wait_idle("abort");
        chk("abort_no_done", uo_out[2], 0);
        tick(2);
        ui_in[1] = 1'b0;
        chk("abort_index", uo_out[6:3], 0);
        chk("abort_frames", frames_seen - f0, 3);
        chk("abort_done_count", done_cycles - d0, 0);
        chk("abort_queue", exp_q.size(), 0);
        tick(4);

        // Second start edge during byte 4 is ignored
        d0 = done_cycles;
        f0 = frames_seen;
        start_banner(10);
        wait_index("restart", 4);
        ui_in[0] = 1'b1;
        tick(3);
        ui_in[0] = 1'b0;
        wait_idle("restart");
        tick(6);
        chk("restart_still_idle", uo_out[1], 0);
        chk("restart_frames", frames_seen - f0, 10);
        chk("restart_done_count", done_cycles - d0, 1);
        chk("restart_queue", exp_q.size(), 0);

        // New banner after done, with a 7-cycle enable freeze mid-DATA
        f0 = frames_seen;
        start_banner(10);
        wait_index("freeze", 1);
        tick(CPB + 3);
        txd_h = uo_out[0];
        idx_h = uo_out[6:3];
        ena = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            chk("freeze_txd", uo_out[0], txd_h);
            chk("freeze_index", uo_out[6:3], idx_h);
        end
        ena = 1'b1;
        wait_idle("freeze");
        tick(2);
        chk("freeze_busy_len", busy_last, BANNER_CYC + 7);
        chk("freeze_frames", frames_seen - f0, 10);
        chk("freeze_queue", exp_q.size(), 0);

        // Reset during byte 5 start bit
        d0 = done_cycles;
        f0 = frames_seen;
        start_banner(10);
        wait_index("rst", 5);
        rst_n = 1'b0;
        tick(1);
        chk("rst_txd", uo_out[0], 1);
        chk("rst_busy", uo_out[1], 0);
        chk("rst_index", uo_out[6:3], 0);
        rst_n = 1'b1;
        chk("rst_pending", exp_q.size(), 5);
        exp_q.delete();
        tick(2 * FRAME_CYC);
        chk("rst_no_done", done_cycles - d0, 0);
        chk("rst_frames", frames_seen - f0, 5);
        chk("rst_stays_idle", uo_out, 8'h01);
        chk("final_done_width", done_run_max, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
